// File: rtl/transc_pipe_pkg.sv
// rtl/transc_pipe_pkg.sv - fixed-point defaults, knee/center defaults and luma LUT generators for transc_pipe
package transc_pipe_pkg;

    // Internal fixed-point format and output width defaults.
    localparam int FP_WIDTH_DEF  = 24;
    localparam int FP_FRAC_DEF   = 12;
    localparam int OUT_WIDTH_DEF = 10;

    // Luma knees and chroma cluster centers at the upper knee.
    localparam int K_L_DEF       = 125;
    localparam int K_H_DEF       = 188;
    localparam int CB_CENTER_DEF = 108;
    localparam int CR_CENTER_DEF = 154;

    localparam int Y_MAX         = 255;

    // Width LUT holds an unsigned scale factor with the internal fraction bits.
    localparam int WIDTH_LUT_W   = 16;

    // How far the cluster center drifts between a knee and the luma extreme.
    localparam int CB_LOW_SWING  = 10;
    localparam int CB_HIGH_SWING = 10;
    localparam int CR_LOW_SWING  = -10;
    localparam int CR_HIGH_SWING = 22;

    // Extra chroma scale (in units of 1.0) reached at the luma extremes, where
    // the skin cluster narrows and must be stretched back to its mid-luma width.
    localparam int CB_LOW_GAIN   = 1;
    localparam int CB_HIGH_GAIN  = 2;
    localparam int CR_LOW_GAIN   = 3;
    localparam int CR_HIGH_GAIN  = 3;

    typedef enum logic {
        CHAN_CB = 1'b0,
        CHAN_CR = 1'b1
    } chan_e;

    // Integer cluster center for a given luma; linear drift outside the knees.
    function automatic int lut_mean(input chan_e chan, input int y, input int k_l,
                                    input int k_h, input int center);
        int swing_lo;
        int swing_hi;
        swing_lo = (chan == CHAN_CB) ? CB_LOW_SWING : CR_LOW_SWING;
        swing_hi = (chan == CHAN_CB) ? CB_HIGH_SWING : CR_HIGH_SWING;
        if (y < k_l)
            return center + ((k_l - y) * swing_lo) / k_l;
        else if (y > k_h)
            return center + ((y - k_h) * swing_hi) / (Y_MAX - k_h);
        else
            return center;
    endfunction

    // Fixed-point chroma scale for a given luma; 1.0 inside the knees.
    function automatic int lut_width(input chan_e chan, input int y, input int k_l,
                                     input int k_h, input int frac);
        int one;
        int gain_lo;
        int gain_hi;
        one     = 1 << frac;
        gain_lo = (chan == CHAN_CB) ? CB_LOW_GAIN : CR_LOW_GAIN;
        gain_hi = (chan == CHAN_CB) ? CB_HIGH_GAIN : CR_HIGH_GAIN;
        if (y < k_l)
            return one + ((k_l - y) * gain_lo * one) / k_l;
        else if (y > k_h)
            return one + ((y - k_h) * gain_hi * one) / (Y_MAX - k_h);
        else
            return one;
    endfunction

endpackage

// File: rtl/transc_pipe_lane.sv
// rtl/transc_pipe_lane.sv - one chroma channel of the transform, S1..S5 datapath (TRANSC_SAT_EN enables saturation)
module transc_lane
    import transc_pipe_pkg::*;
#(
    parameter chan_e CHAN      = CHAN_CB,
    parameter int    FP_WIDTH  = FP_WIDTH_DEF,
    parameter int    FP_FRAC   = FP_FRAC_DEF,
    parameter int    OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int    K_L       = K_L_DEF,
    parameter int    K_H       = K_H_DEF,
    parameter int    CENTER    = CB_CENTER_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        adv,
    input  logic [7:0]                  y,
    input  logic [7:0]                  c,
    input  logic                        band,
    output logic signed [OUT_WIDTH-1:0] out_c,
    output logic                        out_sat
);

    localparam logic signed [FP_WIDTH-1:0] CENTER_FP = FP_WIDTH'(CENTER * (2 ** FP_FRAC));

`ifdef TRANSC_SAT_EN
    localparam logic signed [FP_WIDTH-1:0] OUT_MAX = FP_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [FP_WIDTH-1:0] OUT_MIN = FP_WIDTH'(-(2 ** (OUT_WIDTH - 1)));
`endif

    logic signed [FP_WIDTH-1:0]      mean_lut [256];
    logic        [WIDTH_LUT_W-1:0]   width_lut [256];

    logic signed [FP_WIDTH-1:0]      mean_s1;
    logic        [WIDTH_LUT_W-1:0]   width_s1;
    logic        [7:0]               c_s1;
    logic signed [FP_WIDTH-1:0]      sub_s2;
    logic        [WIDTH_LUT_W-1:0]   width_s2;
    logic        [7:0]               c_s2;
    logic signed [FP_WIDTH-1:0]      prod_s3;
    logic        [7:0]               c_s3;
    logic signed [FP_WIDTH-1:0]      sum_s4;
    logic        [7:0]               c_s4;

    logic signed [FP_WIDTH-1:0]             c_fp;
    logic signed [FP_WIDTH+WIDTH_LUT_W:0]   prod_full;
    logic signed [FP_WIDTH-1:0]             int_part;
    logic signed [OUT_WIDTH-1:0]            res_n;
    logic                                   sat_n;

    // Both LUTs are elaboration-time constants indexed by the S0 luma.
    for (genvar g = 0; g < 256; g++) begin : g_lut
        assign mean_lut[g]  = FP_WIDTH'(lut_mean(CHAN, g, K_L, K_H, CENTER) * (2 ** FP_FRAC));
        assign width_lut[g] = WIDTH_LUT_W'(lut_width(CHAN, g, K_L, K_H, FP_FRAC));
    end

    // Chroma lifted into fixed point and the full-precision scaled product.
    always_comb begin
        c_fp      = {{(FP_WIDTH - 8 - FP_FRAC){1'b0}}, c_s1, {FP_FRAC{1'b0}}};
        prod_full = sub_s2 * $signed({1'b0, width_s2});
    end

    // Output stage: integer part, optional clamp, and pass-through override inside the band.
    always_comb begin
        int_part = sum_s4 >>> FP_FRAC;
        sat_n    = 1'b0;
`ifdef TRANSC_SAT_EN
        if (int_part > OUT_MAX) begin
            res_n = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
            sat_n = 1'b1;
        end else if (int_part < OUT_MIN) begin
            res_n = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
            sat_n = 1'b1;
        end else begin
            res_n = OUT_WIDTH'(int_part);
        end
`else
        res_n = OUT_WIDTH'(int_part);
`endif
        if (band) begin
            res_n = OUT_WIDTH'(c_s4);
            sat_n = 1'b0;
        end
    end

    // S1 LUT, S2 subtract, S3 multiply, S4 add center, S5 output; all hold while adv is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mean_s1  <= '0;
            width_s1 <= '0;
            c_s1     <= '0;
            sub_s2   <= '0;
            width_s2 <= '0;
            c_s2     <= '0;
            prod_s3  <= '0;
            c_s3     <= '0;
            sum_s4   <= '0;
            c_s4     <= '0;
            out_c    <= '0;
            out_sat  <= 1'b0;
        end else if (adv) begin
            mean_s1  <= mean_lut[y];
            width_s1 <= width_lut[y];
            c_s1     <= c;
            sub_s2   <= c_fp - mean_s1;
            width_s2 <= width_s1;
            c_s2     <= c_s1;
            prod_s3  <= FP_WIDTH'(prod_full >>> FP_FRAC);
            c_s3     <= c_s2;
            sum_s4   <= prod_s3 + CENTER_FP;
            c_s4     <= c_s3;
            out_c    <= res_n;
            out_sat  <= sat_n;
        end
    end

endmodule

// File: rtl/transc_pipe.sv
// rtl/transc_pipe.sv - two-channel luma-compensated chroma transform, 6-stage stallable pipe (TRANSC_SAT_EN enables saturation)
module transc_pipe
    import transc_pipe_pkg::*;
#(
    parameter int FP_WIDTH  = FP_WIDTH_DEF,
    parameter int FP_FRAC   = FP_FRAC_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int K_L       = K_L_DEF,
    parameter int K_H       = K_H_DEF,
    parameter int CB_CENTER = CB_CENTER_DEF,
    parameter int CR_CENTER = CR_CENTER_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_y,
    input  logic [7:0]           in_cb,
    input  logic [7:0]           in_cr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_cb,
    output logic [OUT_WIDTH-1:0] out_cr,
    output logic                 out_band,
    output logic [1:0]           out_sat
);

    localparam logic [7:0] KL8 = 8'(K_L);
    localparam logic [7:0] KH8 = 8'(K_H);

    logic       adv;
    logic [5:0] vld;
    logic [7:0] y_s0;
    logic [7:0] cb_s0;
    logic [7:0] cr_s0;
    logic [3:0] band_p;
    logic       band_s0;
    logic       sat_cb;
    logic       sat_cr;

    // The whole pipe moves together; only a held output word blocks it.
    assign adv       = ~vld[5] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[5];
    assign band_s0   = (y_s0 >= KL8) && (y_s0 <= KH8);
    assign out_sat   = {sat_cr, sat_cb};

    // S0 capture, per-stage valid shift and band flag pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld      <= '0;
            y_s0     <= '0;
            cb_s0    <= '0;
            cr_s0    <= '0;
            band_p   <= '0;
            out_band <= 1'b0;
        end else if (adv) begin
            vld      <= {vld[4:0], in_valid};
            y_s0     <= in_y;
            cb_s0    <= in_cb;
            cr_s0    <= in_cr;
            band_p   <= {band_p[2:0], band_s0};
            out_band <= band_p[3];
        end
    end

    transc_lane #(
        .CHAN      (CHAN_CB),
        .FP_WIDTH  (FP_WIDTH),
        .FP_FRAC   (FP_FRAC),
        .OUT_WIDTH (OUT_WIDTH),
        .K_L       (K_L),
        .K_H       (K_H),
        .CENTER    (CB_CENTER)
    ) u_lane_cb (
        .clk     (clk),
        .rst     (rst),
        .adv     (adv),
        .y       (y_s0),
        .c       (cb_s0),
        .band    (band_p[3]),
        .out_c   (out_cb),
        .out_sat (sat_cb)
    );

    transc_lane #(
        .CHAN      (CHAN_CR),
        .FP_WIDTH  (FP_WIDTH),
        .FP_FRAC   (FP_FRAC),
        .OUT_WIDTH (OUT_WIDTH),
        .K_L       (K_L),
        .K_H       (K_H),
        .CENTER    (CR_CENTER)
    ) u_lane_cr (
        .clk     (clk),
        .rst     (rst),
        .adv     (adv),
        .y       (y_s0),
        .c       (cr_s0),
        .band    (band_p[3]),
        .out_c   (out_cr),
        .out_sat (sat_cr)
    );

endmodule

// File: tb/tb_transc_pipe.sv
// tb/tb_transc_pipe.sv - directed self-checking bench for transc_pipe (expects match the TRANSC_SAT_EN setting)
module tb_transc_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_y;
    logic [7:0] in_cb;
    logic [7:0] in_cr;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_cb;
    logic [9:0] out_cr;
    logic       out_band;
    logic [1:0] out_sat;

    typedef struct {
        int         cb;
        int         cr;
        logic       band;
        logic [1:0] sat;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    logic chk_lat  = 1'b1;
    logic last_acc = 1'b0;
    logic held     = 1'b0;
    int   hold_cb;
    int   hold_cr;
    int   hold_band;
    logic vhist [0:1023];

    transc_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_cb     (in_cb),
        .in_cr     (in_cr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cb    (out_cb),
        .out_cr    (out_cr),
        .out_band  (out_band),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs just after the edge, sample 2 ns later, score outputs.
    task automatic step(input logic iv, input logic [7:0] y, input logic [7:0] cb,
                        input logic [7:0] cr, input logic ordy, input int ecb,
                        input int ecr, input logic eband, input logic [1:0] esat);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        in_valid  = iv;
        in_y      = y;
        in_cb     = cb;
        in_cr     = cr;
        out_ready = ordy;
        #1;
        if (held) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_cb", int'($signed(out_cb)), hold_cb);
            check("hold_cr", int'($signed(out_cr)), hold_cr);
            check("hold_band", int'(out_band), hold_band);
        end
        held      = out_valid && !out_ready;
        hold_cb   = int'($signed(out_cb));
        hold_cr   = int'($signed(out_cr));
        hold_band = int'(out_band);
        if (out_valid && out_ready) begin
            check("out_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("out_cb", int'($signed(out_cb)), e.cb);
                check("out_cr", int'($signed(out_cr)), e.cr);
                check("out_band", int'(out_band), int'(e.band));
                check("out_sat", int'(out_sat), int'(e.sat));
                if (chk_lat) check("latency", cyc - e.acc, 6);
                n_out++;
            end
        end
        last_acc   = iv && in_ready;
        vhist[cyc] = last_acc;
        if (last_acc) begin
            e = '{ecb, ecr, eband, esat, cyc};
            q.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 0, 0, 1'b0, 2'b00);
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() > 0 && k < 40) begin
            idle();
            k++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        int i;
        int k;
        int start;
        logic ordy;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_y      = '0;
        in_cb     = '0;
        in_cr     = '0;
        out_ready = 1'b1;
        for (int j = 0; j < 1024; j++) vhist[j] = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_cb", int'(out_cb), 0);
        check("rst_out_cr", int'(out_cr), 0);
        check("rst_out_band", int'(out_band), 0);
        check("rst_out_sat", int'(out_sat), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        // Single pass-through sample, six-cycle latency
        chk_lat = 1'b1;
        step(1'b1, 8'd150, 8'd100, 8'd160, 1'b1, 100, 160, 1'b1, 2'b00);
        drain();

        // Knees, just-outside knees and transformed samples, back to back
        step(1'b1, 8'd188, 8'd50,  8'd60,  1'b1, 50,   60,   1'b1, 2'b00);
        step(1'b1, 8'd125, 8'd255, 8'd0,   1'b1, 255,  0,    1'b1, 2'b00);
        step(1'b1, 8'd189, 8'd108, 8'd154, 1'b1, 108,  154,  1'b0, 2'b00);
        step(1'b1, 8'd124, 8'd118, 8'd254, 1'b1, 118,  256,  1'b0, 2'b00);
        step(1'b1, 8'd0,   8'd100, 8'd130, 1'b1, 72,   98,   1'b0, 2'b00);
        step(1'b1, 8'd255, 8'd120, 8'd200, 1'b1, 114,  250,  1'b0, 2'b00);
        step(1'b1, 8'd62,  8'd100, 8'd140, 1'b1, 88,   131,  1'b0, 2'b00);
        step(1'b1, 8'd62,  8'd0,   8'd0,   1'b1, -62,  -221, 1'b0, 2'b00);
        step(1'b1, 8'd0,   8'd0,   8'd0,   1'b1, -128, -422, 1'b0, 2'b00);
`ifdef TRANSC_SAT_EN
        step(1'b1, 8'd0,   8'd118, 8'd255, 1'b1, 108,  511,  1'b0, 2'b10);
`else
        step(1'b1, 8'd0,   8'd118, 8'd255, 1'b1, 108,  -426, 1'b0, 2'b00);
`endif
        drain();

        // 20-sample stream with a 3-cycle downstream stall while the pipe is full
        chk_lat = 1'b0;
        n_out   = 0;
        i       = 0;
        k       = 0;
        while (i < 20 && k < 80) begin
            ordy = !(k >= 10 && k <= 12);
            step(1'b1, 8'(130 + i), 8'(10 * i + 5), 8'(250 - 7 * i), ordy,
                 10 * i + 5, 250 - 7 * i, 1'b1, 2'b00);
            if (!ordy) check("stall_in_ready", int'(in_ready), 0);
            if (last_acc) i++;
            k++;
        end
        check("stream_sent", i, 20);
        drain();
        check("stream_count", n_out, 20);

        // Reset with four samples in flight
        chk_lat = 1'b1;
        for (int j = 0; j < 4; j++)
            step(1'b1, 8'd140, 8'(j), 8'(j), 1'b1, j, j, 1'b1, 2'b00);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        held = 1'b0;
        #1;
        check("midrst_out_valid_rel", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        for (int j = 0; j < 10; j++) begin
            idle();
            check("midrst_no_stale", int'(out_valid), 0);
        end
        step(1'b1, 8'd160, 8'd33, 8'd44, 1'b1, 33, 44, 1'b1, 2'b00);
        drain();

        // in_valid toggling every other cycle
        start = cyc + 1;
        for (int t = 0; t < 22; t++) begin
            if (t < 14)
                step(1'(t % 2 == 0), 8'd140, 8'(20 + t), 8'(30 + t), 1'b1,
                     20 + t, 30 + t, 1'b1, 2'b00);
            else
                idle();
            if (cyc - 6 >= start) check("toggle_valid", int'(out_valid), int'(vhist[cyc - 6]));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
